// File: rtl/fch_rsp_unit.sv
// Fetch responder: accepts PCs from the IFU, issues single-cycle-latency reads to an
// instruction SRAM and returns instruction words in request order. A small response
// FIFO absorbs read data while the IFU stalls the response channel; a credit counter
// bounds the number of outstanding requests so that no read data is ever dropped.
module fch_rsp_unit #(
   parameter int unsigned PC_W   = 32,
   parameter int unsigned IR_W   = 32,
   parameter int unsigned DEPTH  = 2,
   parameter int unsigned MEM_AW = 12,
   parameter logic [IR_W-1:0] BAD_IR = '0
) (
   input  logic              clk,
   input  logic              rst,
   // request channel (IFU is master)
   input  logic              fch_req_vld,
   output logic              fch_req_rdy,
   input  logic [PC_W-1:0]   fch_req_pc,
   // response channel (IFU is slave)
   output logic              fch_rsp_vld,
   input  logic              fch_rsp_rdy,
   output logic [IR_W-1:0]   fch_rsp_ir,
   // instruction SRAM
   output logic              mem_en,
   output logic [MEM_AW-1:0] mem_addr,
   input  logic [IR_W-1:0]   mem_rdata
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

   // pointer advance with wrap at the last FIFO slot
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
   endfunction

   // credit counter: requests accepted but not yet answered (inflight + FIFO)
   logic [CNT_W-1:0]  outst_q, outst_d;
   // read issued last cycle; its data is on mem_rdata (or BAD_IR) this cycle
   logic              inflight_q, inflight_d;
   logic              bad_q, bad_d;
   // response FIFO control
   logic [CNT_W-1:0]  fifo_cnt_q, fifo_cnt_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   // last issued SRAM address, held between reads
   logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
   // response FIFO storage (data only, never reset)
   logic [IR_W-1:0]   fifo_mem_q [DEPTH];

   logic              req_hsk;
   logic              rsp_hsk;
   logic              pc_legal;
   logic              fifo_empty;
   logic              fifo_push;
   logic              fifo_pop;
   logic [IR_W-1:0]   infl_data;

   assign req_hsk    = fch_req_vld & fch_req_rdy;
   assign rsp_hsk    = fch_rsp_vld & fch_rsp_rdy;
   assign fifo_empty = (fifo_cnt_q == '0);
   // word-aligned and inside the SRAM window; anything else is answered with BAD_IR
   assign pc_legal   = (fch_req_pc[1:0] == 2'b00) && ((fch_req_pc >> (MEM_AW + 2)) == '0);
   assign infl_data  = bad_q ? BAD_IR : mem_rdata;
   // bypass the FIFO only when it is empty and the consumer takes the word now
   assign fifo_push  = inflight_q & ~(fifo_empty & rsp_hsk);
   assign fifo_pop   = rsp_hsk & ~fifo_empty;

   // accept while a credit is free, or when a response leaves in this same cycle
   always_comb begin
      fch_req_rdy = ~rst & ((outst_q < DEPTH_C) | rsp_hsk);
   end

   // response source: FIFO head when occupied, otherwise the inflight word
   always_comb begin
      fch_rsp_vld = 1'b0;
      fch_rsp_ir  = '0;
      if (!fifo_empty) begin
         fch_rsp_vld = 1'b1;
         fch_rsp_ir  = fifo_mem_q[rd_ptr_q];
      end else if (inflight_q) begin
         fch_rsp_vld = 1'b1;
         fch_rsp_ir  = infl_data;
      end
   end

   // SRAM strobe only for legal accepted PCs; the address holds otherwise
   always_comb begin
      mem_en     = req_hsk & pc_legal;
      mem_addr   = mem_en ? fch_req_pc[MEM_AW+1:2] : mem_addr_q;
      mem_addr_d = mem_addr;
   end

   // next-state for credits, inflight stage and FIFO pointers
   always_comb begin
      inflight_d = req_hsk;
      bad_d      = req_hsk & ~pc_legal;

      outst_d = outst_q;
      case ({req_hsk, rsp_hsk})
         2'b10:   outst_d = outst_q + CNT_W'(1);
         2'b01:   outst_d = outst_q - CNT_W'(1);
         default: outst_d = outst_q;
      endcase

      fifo_cnt_d = fifo_cnt_q;
      case ({fifo_push, fifo_pop})
         2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
         2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
         default: fifo_cnt_d = fifo_cnt_q;
      endcase

      wr_ptr_d = fifo_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = fifo_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
   end

   // control state; reset discards everything in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         outst_q    <= '0;
         inflight_q <= 1'b0;
         bad_q      <= 1'b0;
         fifo_cnt_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         mem_addr_q <= '0;
      end else begin
         outst_q    <= outst_d;
         inflight_q <= inflight_d;
         bad_q      <= bad_d;
         fifo_cnt_q <= fifo_cnt_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         mem_addr_q <= mem_addr_d;
      end
   end

   // FIFO storage: capture the inflight word when it cannot be handed over directly
   always_ff @(posedge clk) begin
      if (fifo_push) begin
         fifo_mem_q[wr_ptr_q] <= infl_data;
      end
   end

endmodule

// File: tb/tb_fch_rsp_unit.sv
// Bench for fch_rsp_unit: directed scenarios plus a randomized stream, checked against
// a transaction-level model (queue of expected instruction words with accept cycles).
module tb_fch_rsp_unit;

   localparam int DEPTH  = 2;
   localparam int MEM_AW = 4;
   localparam logic [31:0] BAD_IR = 32'h0BAD_0BAD;

   logic              clk = 1'b0;
   logic              rst;
   logic              req_vld;
   logic              req_rdy;
   logic [31:0]       req_pc;
   logic              rsp_vld;
   logic              rsp_rdy;
   logic [31:0]       rsp_ir;
   logic              mem_en;
   logic [MEM_AW-1:0] mem_addr;
   logic [31:0]       mem_rdata = '0;

   logic [31:0]       mem [2**MEM_AW];

   typedef struct {
      logic [31:0] ir;
      int          cyc;
   } exp_t;

   exp_t              q[$];
   int                cyc = 0;
   logic [MEM_AW-1:0] last_addr = '0;
   int                n_cmp = 0;
   int                n_bad = 0;

   fch_rsp_unit #(
      .PC_W   (32),
      .IR_W   (32),
      .DEPTH  (DEPTH),
      .MEM_AW (MEM_AW),
      .BAD_IR (BAD_IR)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .fch_req_vld (req_vld),
      .fch_req_rdy (req_rdy),
      .fch_req_pc  (req_pc),
      .fch_rsp_vld (rsp_vld),
      .fch_rsp_rdy (rsp_rdy),
      .fch_rsp_ir  (rsp_ir),
      .mem_en      (mem_en),
      .mem_addr    (mem_addr),
      .mem_rdata   (mem_rdata)
   );

   always #5 clk = ~clk;

   // synchronous SRAM: data appears the cycle after the strobe
   always @(posedge clk) begin
      if (mem_en) mem_rdata <= mem[mem_addr];
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // a write into a full FIFO must never happen
   always @(negedge clk) begin
      if (!rst && dut.fifo_push)
         chk("push_not_full", {31'b0, (int'(dut.fifo_cnt_q) < DEPTH)}, 32'd1);
   end

   // one clock: check outputs against the model mid-cycle, update the model, advance
   task automatic cycle_chk(output bit acc);
      logic legal, exp_vld, exp_rdy, rhsk, qhsk;
      @(negedge clk);
      exp_vld = (q.size() > 0) && (q[0].cyc < cyc);
      rhsk    = exp_vld && rsp_rdy;
      exp_rdy = (q.size() < DEPTH) || rhsk;
      legal   = (req_pc[1:0] == 2'b00) && ((req_pc >> (MEM_AW + 2)) == 32'd0);
      qhsk    = req_vld && exp_rdy;
      chk("rsp_vld", {31'b0, rsp_vld}, {31'b0, exp_vld});
      if (exp_vld) chk("rsp_ir", rsp_ir, q[0].ir);
      chk("req_rdy", {31'b0, req_rdy}, {31'b0, exp_rdy});
      chk("mem_en", {31'b0, mem_en}, {31'b0, qhsk && legal});
      if (qhsk && legal) last_addr = req_pc[MEM_AW+1:2];
      chk("mem_addr", 32'(mem_addr), 32'(last_addr));
      if (rhsk) void'(q.pop_front());
      if (qhsk) q.push_back('{ir: (legal ? mem[req_pc[MEM_AW+1:2]] : BAD_IR), cyc: cyc});
      acc = qhsk;
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      bit acc;
      int n = 0;
      req_vld = 1'b0;
      rsp_rdy = 1'b1;
      while (q.size() > 0 && n < 20) begin
         cycle_chk(acc);
         n++;
      end
      chk("drain_done", 32'(q.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit acc;
      int acc_n;
      int pcw;
      for (int i = 0; i < 2**MEM_AW; i++) mem[i] = '0;
      rst = 1'b1; req_vld = 1'b0; req_pc = '0; rsp_rdy = 1'b0;

      // reset state, with a request offered during reset
      repeat (2) @(posedge clk);
      #1;
      req_vld = 1'b1;
      #1;
      chk("rst_rsp_vld", {31'b0, rsp_vld}, 32'd0);
      chk("rst_rsp_ir", rsp_ir, 32'd0);
      chk("rst_req_rdy", {31'b0, req_rdy}, 32'd0);
      chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      @(posedge clk);
      #1;

      // first request right after reset release
      mem[0] = 32'h0000_0013;
      rst = 1'b0; req_vld = 1'b1; req_pc = 32'h0; rsp_rdy = 1'b1;
      cycle_chk(acc);
      chk("first_acc", {31'b0, acc}, 32'd1);
      req_vld = 1'b0;
      cycle_chk(acc);
      cycle_chk(acc);

      // back-to-back stream
      for (int i = 0; i < 4; i++) mem[i] = 32'h100 + 32'(i);
      rsp_rdy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         req_vld = 1'b1;
         req_pc = 32'(i) << 2;
         cycle_chk(acc);
         chk("stream_acc", {31'b0, acc}, 32'd1);
      end
      drain();

      // backpressure: only DEPTH requests are taken while the IFU stalls
      for (int i = 0; i < 8; i++) mem[i] = 32'h200 + 32'(i);
      rsp_rdy = 1'b0; acc_n = 0; pcw = 0;
      for (int i = 0; i < 5; i++) begin
         req_vld = 1'b1;
         req_pc = 32'(pcw) << 2;
         cycle_chk(acc);
         if (acc) begin acc_n++; pcw++; end
      end
      chk("bp_accepted", 32'(acc_n), 32'(DEPTH));
      drain();

      // illegal PCs: misaligned, then just past the SRAM window
      rsp_rdy = 1'b1;
      req_vld = 1'b1; req_pc = 32'h2;
      cycle_chk(acc);
      req_pc = 32'(4 * (2**MEM_AW));
      cycle_chk(acc);
      drain();

      // full, then rsp.rdy rises together with a new request
      rsp_rdy = 1'b0; pcw = 0;
      for (int i = 0; i < 3; i++) begin
         req_vld = 1'b1;
         req_pc = 32'(pcw) << 2;
         cycle_chk(acc);
         if (acc) pcw++;
      end
      rsp_rdy = 1'b1; req_pc = 32'(pcw) << 2;
      cycle_chk(acc);
      chk("full_rise_acc", {31'b0, acc}, 32'd1);
      rsp_rdy = 1'b0; req_pc = 32'(pcw + 1) << 2;
      cycle_chk(acc);
      chk("full_hold_noacc", {31'b0, acc}, 32'd0);
      drain();

      // reset in the middle of a stream with two entries outstanding
      rsp_rdy = 1'b0; pcw = 4;
      for (int i = 0; i < 3; i++) begin
         req_vld = 1'b1;
         req_pc = 32'(pcw) << 2;
         cycle_chk(acc);
         if (acc) pcw++;
      end
      chk("pre_rst_outst", 32'(q.size()), 32'(DEPTH));
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_rsp_vld", {31'b0, rsp_vld}, 32'd0);
      chk("mid_rst_mem_en", {31'b0, mem_en}, 32'd0);
      chk("mid_rst_req_rdy", {31'b0, req_rdy}, 32'd0);
      q.delete();
      last_addr = '0;
      @(posedge clk);
      #1;
      mem[0] = 32'hFEED_0001;
      rst = 1'b0; req_vld = 1'b1; req_pc = 32'h0; rsp_rdy = 1'b1;
      cycle_chk(acc);
      req_vld = 1'b0;
      cycle_chk(acc);
      drain();

      // randomized traffic with random backpressure
      for (int i = 0; i < 2**MEM_AW; i++) mem[i] = $urandom;
      for (int i = 0; i < 400; i++) begin
         int r;
         r = int'($urandom_range(0, 9));
         req_vld = ($urandom_range(0, 9) < 7);
         if (r == 0)      req_pc = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
         else if (r == 1) req_pc = ($urandom & 32'hFFFF_FFFC) | 32'h100;
         else             req_pc = 32'($urandom_range(0, 15)) << 2;
         rsp_rdy = ($urandom_range(0, 9) < 6);
         cycle_chk(acc);
      end
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
